// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache constants: fill FSM states and block geometry.
// Used by the cache, memory controller and fill FSM.
package cache_fill_fsm_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_e;

  localparam int CACHE_WORDS_PER_BLOCK = 8;
  localparam int BLK_OFF_W = 4;
  localparam int CNT_W = 4;
  localparam int ADDR_W = 16;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache line fill sequencer: issues one read per word, then
// writes returned words and finally the tag/valid entry.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK =
    cache_fill_fsm_pkg::CACHE_WORDS_PER_BLOCK,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  fill_word_idx,
  output logic        write_tag_array
);

  import cache_fill_fsm_pkg::*;

  if ((MEM_LATENCY < 1) || (WORDS_PER_BLOCK > 8)) begin : g_bad_cfg
    $error("cache_fill_fsm: unsupported parameters");
  end

  localparam logic [CNT_W-1:0] LP_N =
    CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_e r_state;
  fill_state_e w_next;

  logic [ADDR_W-BLK_OFF_W-1:0] r_base;
  logic [BLK_OFF_W-1:0]        w_unused_off;
  logic [CNT_W-1:0]            w_issue_cnt;
  logic [CNT_W-1:0]            w_recv_cnt;

  logic w_fill;
  logic w_start;
  logic w_issue;
  logic w_accept;
  logic w_last;

  assign w_unused_off = miss_address[BLK_OFF_W-1:0];

  assign w_fill   = (r_state == S_FILL);
  assign w_start  = !w_fill && miss_detected;
  assign w_issue  = w_fill && (w_issue_cnt < LP_N);
  assign w_accept = w_fill && memory_data_valid
                 && (w_recv_cnt < LP_N);
  assign w_last   = w_accept && (w_recv_cnt == LP_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (miss_detected) w_next = S_FILL;
      S_FILL:  if (w_last)        w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Only the block base is kept; later address changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (w_start) begin
      r_base <= miss_address[ADDR_W-1:BLK_OFF_W];
    end
  end

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_issue),
    .i_clr (w_start),
    .o_cnt (w_issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_accept),
    .i_clr (w_start),
    .o_cnt (w_recv_cnt)
  );

  assign fsm_busy         = w_fill;
  assign mem_read_en      = w_issue;
  assign memory_address   = w_issue
    ? {r_base, w_issue_cnt[2:0], 1'b0} : '0;
  assign write_data_array = w_accept;
  assign fill_word_idx    = w_fill ? w_recv_cnt[2:0] : '0;
  assign write_tag_array  = w_last;

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter: WORDS_PER_BLOCK, default 8, number of 16-bit words per cache block (16-byte block).
REQ-002 Parameter: MEM_LATENCY, default 4, cycles from a read issue to its memory_data_valid.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 Port: miss_detected  input  1  cache lookup missed this cycle (from the I- or D-cache tag compare).
REQ-006 Port: miss_address  input  16  byte address of the missing access.
REQ-007 Port: memory_data_valid  input  1  memory returns one word this cycle.
REQ-008 Port: fsm_busy  output  1  fill in progress; the CPU stalls its pipeline on fsm_busy.
REQ-009 Port: mem_read_en  output  1  issue one read to multi-cycle main memory this cycle.
REQ-010 Port: memory_address  output  16  word-aligned read address for the current issue.
REQ-011 Port: write_data_array  output  1  write the returned word into the cache data array.
REQ-012 Port: fill_word_idx  output  3  word slot (0-7) within the block for write_data_array.
REQ-013 Port: write_tag_array  output  1  write tag and valid for the filled block.

Function
REQ-014 States: IDLE and FILL, with a 2-state register.
REQ-015 IDLE->FILL on rising clk when miss_detected=1; latch block base miss_address[15:4]; clear issue_cnt and recv_cnt.
REQ-016 In FILL, ignore miss_detected and changes to miss_address; use only the latched base.
REQ-017 fsm_busy = (state==FILL), registered; no combinational path from miss_detected.
REQ-018 In FILL while issue_cnt<WORDS_PER_BLOCK: mem_read_en=1 and memory_address={base,issue_cnt[2:0],1'b0}; issue_cnt increments every cycle, giving back-to-back issues with no gaps.
REQ-019 After 8 issues, mem_read_en=0; issue_cnt saturates at 8.
REQ-020 write_data_array = memory_data_valid & (state==FILL) & (recv_cnt<8); fill_word_idx = recv_cnt[2:0]; recv_cnt increments on each accepted valid.
REQ-021 On the cycle the 8th word is accepted, write_tag_array=1 for exactly that cycle; the next state is IDLE.
REQ-022 Nominal timing: miss sampled at edge 0 -> issues in cycles 1-8 -> valids in cycles 5-12 -> write_tag_array in cycle 12 -> IDLE and fsm_busy=0 from cycle 13 (12 busy cycles).
REQ-023 Ignore memory_data_valid in IDLE (no write strobes) and any valid beyond the 8th.
REQ-024 Do not time returns: completion depends only on the count of 8 valids, so any MEM_LATENCY>=1 works.
REQ-025 In IDLE: mem_read_en, write_data_array and write_tag_array are 0; memory_address=16'h0000; fill_word_idx=0.
REQ-026 If miss_detected is high in the cycle after completion (IDLE), start a new fill immediately.
REQ-027 Address arithmetic is pure concatenation; there is no carry out of the word index, so a block at 16'hFFF0 issues 16'hFFF0 through 16'hFFFE.

Reset
REQ-028 rst_n=0 forces, asynchronously: state=IDLE, issue_cnt=0, recv_cnt=0, latched base=0, and all outputs to their REQ-025 values with fsm_busy=0.
REQ-029 Reset asserted mid-fill abandons the fill with no tag write; returns still in flight after release are ignored under REQ-023.

Structure
REQ-030 State encodings, WORDS_PER_BLOCK and block-offset width belong in the shared cache constants package, which the cache and memory-controller blocks also use.
REQ-031 One sub-module, fill_counter: 4-bit saturating incrementer with enable, clear and async active-low reset, instantiated twice (issue_cnt, recv_cnt).

Verification
REQ-032 Miss at 16'h1234, latency 4 -> addresses 16'h1230, 1232, ..., 123E in cycles 1-8; write_data_array in cycles 5-12 with idx 0-7; write_tag_array only in cycle 12; fsm_busy cycles 1-12.
REQ-033 Valids with gaps (cycles 5,6,9,10,11,14,15,16) -> idx increments only on valids; write_tag_array in cycle 16; fsm_busy falls at cycle 17.
REQ-034 miss_address changed to 16'hABCD and miss_detected pulsed during FILL -> issued addresses are unchanged and no second fill starts.
REQ-035 rst_n low in cycle 7 of a fill -> all outputs 0 immediately; late valids produce no writes; a new miss at 16'h0040 then completes a normal fill.
REQ-036 Back-to-back misses 16'h0000 then 16'hFFF0 (second held high through completion) -> second fill starts the cycle after the first write_tag_array; addresses 16'hFFF0-16'hFFFE with no wrap.
